// File: rtl/fp32_sum_seq.sv
// rtl/fp32_sum_seq.sv - sequential fp32 vector reduction driving a fixed-latency adder
// Folds a valid/ready element stream into a running sum, one adder issue at a time.
module fp32_sum_seq #(
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int WAIT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {S_ACC, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_last;
  logic [31:0]       r_acc;
  logic [31:0]       r_add_a;
  logic [31:0]       r_add_b;
  logic [31:0]       r_out_data;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_out_count;
  logic              w_accept;
  logic              w_capture;
  logic              w_out_fire;

  // Gated by rst_n so the producer never sees ready while reset is held.
  assign in_ready   = (r_state == S_ACC) & rst_n;
  assign w_accept   = in_valid & in_ready;
  assign w_capture  = (r_state == S_WAIT) && (r_wait == '0);
  assign w_out_fire = (r_state == S_DONE) & out_ready;

  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign out_data   = r_out_data;
  assign out_count  = r_out_count;
  assign out_valid  = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_ACC;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACC:   if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_capture) w_state_nxt = r_last ? S_DONE : S_ACC;
      S_DONE:  if (out_ready) w_state_nxt = S_ACC;
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait      <= '0;
      r_last      <= 1'b0;
      r_acc       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_out_data  <= '0;
      r_count     <= '0;
      r_out_count <= '0;
    end else begin
      if (w_accept) begin
        r_add_a <= r_acc;
        r_add_b <= in_data;
        r_last  <= in_last;
        r_wait  <= WAIT_W'(LAT);
        if (r_count != '1) r_count <= r_count + CNT_W'(1);
      end
      // Operands stay parked on add_a/add_b; only the counter moves until the result lands.
      if (r_state == S_WAIT) begin
        if (r_wait != '0) begin
          r_wait <= r_wait - WAIT_W'(1);
        end else begin
          r_acc <= add_result;
          if (r_last) begin
            r_out_data  <= add_result;
            r_out_count <= r_count;
          end
        end
      end
      if (w_out_fire) begin
        r_acc   <= '0;
        r_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fp32_sum_seq.sv
// tb/tb_fp32_sum_seq.sv - directed self-checking bench for fp32_sum_seq
// Drives LAT=2 and LAT=3 instances, each fed by a table-driven pipelined adder model.
module tb_fp32_sum_seq;

  localparam logic [31:0] F_ONE   = 32'h3F800000;
  localparam logic [31:0] F_TWO   = 32'h40000000;
  localparam logic [31:0] F_THREE = 32'h40400000;
  localparam logic [31:0] F_SIX   = 32'h40C00000;
  localparam logic [31:0] F_PINF  = 32'h7F800000;
  localparam logic [31:0] F_NINF  = 32'hFF800000;
  localparam logic [31:0] F_QNAN  = 32'h7FC00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] in_data, add_a, add_b, add_result, out_data;
  logic        in_valid, in_last, in_ready, out_valid, out_ready;
  logic [15:0] out_count;

  logic [31:0] in_data3, add_a3, add_b3, add_result3, out_data3;
  logic        in_valid3, in_last3, in_ready3, out_valid3, out_ready3;
  logic [15:0] out_count3;

  int checks = 0;
  int errors = 0;

  fp32_sum_seq #(.LAT(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .out_data(out_data), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  fp32_sum_seq #(.LAT(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
    .in_ready(in_ready3), .add_a(add_a3), .add_b(add_b3), .add_result(add_result3),
    .out_data(out_data3), .out_count(out_count3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  // Adder stand-in: knows only the sums these vectors need; anything else is a poison value.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    if (a == F_ONE   && b == F_TWO)  return F_THREE;
    if (a == F_THREE && b == F_THREE) return F_SIX;
    if (a == F_PINF  && b == F_NINF) return F_QNAN;
    return 32'hDEADBEEF;
  endfunction

  logic [31:0] p2 [2];
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p2[0] <= fadd(add_a, add_b);
    p2[1] <= p2[0];
    p3[0] <= fadd(add_a3, add_b3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign add_result  = p2[1];
  assign add_result3 = p3[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 20 && !in_ready; n++) step();
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_last = 0; in_data = 0; out_ready = 0;
    in_valid3 = 0; in_last3 = 0; in_data3 = 0; out_ready3 = 0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (add_a !== 32'h0 || add_b !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h %h want 0 0", add_a, add_b); end
    checks++; if (out_data !== 32'h0 || out_count !== 16'h0) begin errors++; $display("FAIL reset_out: got %h %h want 0 0", out_data, out_count); end
    checks++; if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_lat3: got ready=%b valid=%b want 1 0", in_ready3, out_valid3); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = F_THREE; in_last = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept: got %b want 1", in_ready); end
    for (int c = 1; c <= 4; c++) begin
      step();
      in_valid = 1'b0; in_last = 1'b0;
      if (c <= 3) begin
        checks++; if (add_a !== 32'h0 || add_b !== F_THREE) begin errors++; $display("FAIL single_ops c%0d: got %h %h want 0 %h", c, add_a, add_b, F_THREE); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL single_wait c%0d: got valid=%b ready=%b want 0 0", c, out_valid, in_ready); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid c4: got %b want 1", out_valid); end
        checks++; if (out_data !== F_THREE || out_count !== 16'd1) begin errors++; $display("FAIL single_result: got %h cnt %0d want %h cnt 1", out_data, out_count, F_THREE); end
      end
    end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_after: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_three();
    logic [31:0] el [3];
    int idx;
    logic acc_now;
    el[0] = F_ONE; el[1] = F_TWO; el[2] = F_THREE;
    idx = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = el[0]; in_last = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      checks++; if (in_ready !== ((c % 4 == 0) && c <= 8)) begin errors++; $display("FAIL three_ready c%0d: got %b want %b", c, in_ready, ((c % 4 == 0) && c <= 8)); end
      checks++; if (out_valid !== (c == 12)) begin errors++; $display("FAIL three_valid c%0d: got %b want %b", c, out_valid, (c == 12)); end
      if (c == 12) begin
        checks++; if (out_data !== F_SIX || out_count !== 16'd3) begin errors++; $display("FAIL three_result: got %h cnt %0d want %h cnt 3", out_data, out_count, F_SIX); end
      end
      acc_now = in_valid & in_ready;
      step();
      if (acc_now) begin
        idx++;
        if (idx < 3) begin in_data = el[idx]; in_last = (idx == 2); end
        else begin in_valid = 1'b0; in_last = 1'b0; end
      end
    end
  endtask

  task automatic test_inf();
    int n;
    out_ready = 1'b1;
    send(F_PINF, 1'b0);
    send(F_NINF, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL inf_timeout: got %b want 1", out_valid); end
    checks++; if (out_data !== F_QNAN || out_count !== 16'd2) begin errors++; $display("FAIL inf_result: got %h cnt %0d want %h cnt 2", out_data, out_count, F_QNAN); end
    step();
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    send(F_ONE, 1'b0);
    send(F_TWO, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: got %b want 1", out_valid); end
    in_valid = 1'b1; in_data = F_ONE; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got valid=%b ready=%b want 1 0", i, out_valid, in_ready); end
      checks++; if (out_data !== F_THREE || out_count !== 16'd2) begin errors++; $display("FAIL bp_stable%0d: got %h cnt %0d want %h cnt 2", i, out_data, out_count, F_THREE); end
      step();
    end
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_handshake: got %b want 1", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_after: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    checks++; if (out_data !== F_ONE || out_count !== 16'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_next: got %h cnt %0d v=%b want %h cnt 1 v=1", out_data, out_count, out_valid, F_ONE); end
    step();
  endtask

  task automatic test_reset_in_wait();
    int n;
    out_ready = 1'b1;
    send(F_ONE, 1'b0);
    send(F_THREE, 1'b0);
    step();
    rst_n = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rw_ready_c2: got %b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rw_in_reset: got ready=%b valid=%b want 0 0", in_ready, out_valid); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rw_release: got ready=%b valid=%b want 1 0", in_ready, out_valid); end
    send(F_TWO, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    checks++; if (out_data !== F_TWO || out_count !== 16'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL rw_result: got %h cnt %0d v=%b want %h cnt 1 v=1", out_data, out_count, out_valid, F_TWO); end
    step();
  endtask

  task automatic test_lat3();
    logic [31:0] el [3];
    int idx;
    logic acc_now;
    el[0] = F_ONE; el[1] = F_TWO; el[2] = F_THREE;
    idx = 0;
    out_ready3 = 1'b1;
    in_valid3 = 1'b1; in_data3 = el[0]; in_last3 = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      checks++; if (in_ready3 !== ((c % 5 == 0) && c <= 10)) begin errors++; $display("FAIL lat3_ready c%0d: got %b want %b", c, in_ready3, ((c % 5 == 0) && c <= 10)); end
      checks++; if (out_valid3 !== (c == 15)) begin errors++; $display("FAIL lat3_valid c%0d: got %b want %b", c, out_valid3, (c == 15)); end
      if (c == 15) begin
        checks++; if (out_data3 !== F_SIX || out_count3 !== 16'd3) begin errors++; $display("FAIL lat3_result: got %h cnt %0d want %h cnt 3", out_data3, out_count3, F_SIX); end
      end
      acc_now = in_valid3 & in_ready3;
      step();
      if (acc_now) begin
        idx++;
        if (idx < 3) begin in_data3 = el[idx]; in_last3 = (idx == 2); end
        else begin in_valid3 = 1'b0; in_last3 = 1'b0; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_inf();
    test_backpressure();
    test_reset_in_wait();
    test_lat3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
